ps2_hex_entry: RTL and testbench

//   PS/2 keyboard receiver + scancode decoder for hex operand entry on the FPGA board.

---
 rtl/ps2_hex_entry.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_hex_entry.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_hex_entry.sv
// PS/2 keyboard receiver and scan-set-2 decoder for hex operand entry.
// Typed hex digits are shifted into value_o. Enter commits, Backspace drops a digit, Esc clears.
module ps2_hex_entry #(
    parameter int DISPLAY_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     ps2_clk_i,
    input  logic                     ps2_data_i,
    output logic [DISPLAY_WIDTH-1:0] value_o,
    output logic                     key_stb_o,
    output logic                     value_valid_o,
    output logic                     frame_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;
    logic fall;

    rx_state_e state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rx_stb_q, rx_stb_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          err_q, err_d;

    logic                     brk_q, ext_q;
    logic [DISPLAY_WIDTH-1:0] value_q;
    logic                     key_stb_q, valid_q;
    logic                     is_hex;
    logic [3:0]               nibble;

    // Both PS/2 lines are asynchronous; they idle high, so the synchronizers reset to 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_i;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_i;
            data_sync <= data_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            rx_stb_q  <= 1'b0;
            rx_byte_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            rx_stb_q  <= rx_stb_d;
            rx_byte_q <= rx_byte_d;
            err_q     <= err_d;
        end
    end

    // A clock fall always takes priority over the timeout in the same cycle.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        rx_stb_d  = 1'b0;
        rx_byte_d = rx_byte_q;
        err_d     = 1'b0;

        if (state_q == IDLE || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!data_sync) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_sync, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = data_sync;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_sync && (^{shift_q, par_q})) begin
                        rx_stb_d  = 1'b1;
                        rx_byte_d = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
    end

    always_comb begin
        is_hex = 1'b1;
        nibble = 4'h0;
        case (rx_byte_q)
            8'h45: nibble = 4'h0;
            8'h16: nibble = 4'h1;
            8'h1E: nibble = 4'h2;
            8'h26: nibble = 4'h3;
            8'h25: nibble = 4'h4;
            8'h2E: nibble = 4'h5;
            8'h36: nibble = 4'h6;
            8'h3D: nibble = 4'h7;
            8'h3E: nibble = 4'h8;
            8'h46: nibble = 4'h9;
            8'h1C: nibble = 4'hA;
            8'h32: nibble = 4'hB;
            8'h21: nibble = 4'hC;
            8'h23: nibble = 4'hD;
            8'h24: nibble = 4'hE;
            8'h2B: nibble = 4'hF;
            default: is_hex = 1'b0;
        endcase
    end

    // Release codes (F0 xx) are swallowed whole; E0 only matters for keypad Enter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            value_q   <= '0;
            key_stb_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            key_stb_q <= 1'b0;
            valid_q   <= 1'b0;
            if (err_q) begin
                brk_q <= 1'b0;
                ext_q <= 1'b0;
            end else if (rx_stb_q) begin
                if (rx_byte_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (rx_byte_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else if (brk_q) begin
                    brk_q <= 1'b0;
                    ext_q <= 1'b0;
                end else if (ext_q) begin
                    ext_q <= 1'b0;
                    if (rx_byte_q == 8'h5A) begin
                        valid_q <= 1'b1;
                    end
                end else if (is_hex) begin
                    value_q   <= {value_q[DISPLAY_WIDTH-5:0], nibble};
                    key_stb_q <= 1'b1;
                end else begin
                    case (rx_byte_q)
                        8'h66:   value_q <= value_q >> 4;
                        8'h76:   value_q <= '0;
                        8'h5A:   valid_q <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign value_o       = value_q;
    assign key_stb_o     = key_stb_q;
    assign value_valid_o = valid_q;
    assign frame_err_o   = err_q;

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Self-checking bench for ps2_hex_entry: bit-bangs PS/2 frames and scoreboards the output pulses.
module tb_ps2_hex_entry;

    localparam int W      = 32;
    localparam int TMO    = 300;
    localparam int HALF   = 25;
    localparam int GAP    = 40;
    localparam int SETTLE = 10;

    localparam logic [2:0] EV_KEY = 3'b001;
    localparam logic [2:0] EV_VAL = 3'b010;
    localparam logic [2:0] EV_ERR = 3'b100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ps2_clk = 1'b1;
    logic         ps2_data = 1'b1;
    logic [W-1:0] value;
    logic         key_stb, value_valid, frame_err;

    int checks = 0;
    int failures = 0;
    int rd_idx = 0;
    logic [W-1:0] exp_val = '0;
    logic [W+2:0] exp_q[$];
    logic [W+2:0] obs_q[$];
    logic [W+2:0] exp_ev, obs_ev;

    ps2_hex_entry #(
        .DISPLAY_WIDTH (W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .value_o      (value),
        .key_stb_o    (key_stb),
        .value_valid_o(value_valid),
        .frame_err_o  (frame_err)
    );

    always #5 clk = ~clk;

    // Record every output pulse with the value seen alongside it.
    always @(negedge clk) begin
        if (rst_n && (key_stb || value_valid || frame_err)) begin
            obs_q.push_back({frame_err, value_valid, key_stb, value});
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
        ps2_data = 1'b1;
    endtask

    task automatic push_digit(input logic [3:0] nib);
        exp_val = {exp_val[W-5:0], nib};
        exp_q.push_back({EV_KEY, exp_val});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (value !== '0) begin
            failures++;
            $display("[TB] FAIL reset_value: got %h expected 0", value);
        end
        checks++;
        if ({key_stb, value_valid, frame_err} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_pulses: got %b expected 000", {key_stb, value_valid, frame_err});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_val = '0;
    endtask

    task automatic test_press_release();
        push_digit(4'h1);
        send_frame(8'h16, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h16, 0, 0);
        repeat (SETTLE) @(negedge clk);
        while (exp_q.size() != 0) begin
            exp_ev = exp_q.pop_front();
            checks++;
            if (rd_idx >= obs_q.size()) begin
                failures++;
                $display("[TB] FAIL press_evt: got none expected %h", exp_ev);
            end else begin
                obs_ev = obs_q[rd_idx];
                rd_idx++;
                if (obs_ev !== exp_ev) begin
                    failures++;
                    $display("[TB] FAIL press_evt: got %h expected %h", obs_ev, exp_ev);
                end
            end
        end
        checks++;
        if (obs_q.size() != rd_idx) begin
            failures++;
            $display("[TB] FAIL press_extra: got %0d events expected %0d", obs_q.size(), rd_idx);
            rd_idx = obs_q.size();
        end
        checks++;
        if (value !== 32'h0000_0001) begin
            failures++;
            $display("[TB] FAIL press_value: got %h expected 00000001", value);
        end
    endtask

    task automatic test_ten_digits();
        logic [7:0] codes [10];
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h1C};
        send_frame(8'h76, 0, 0);
        exp_val = '0;
        for (int i = 0; i < 10; i++) begin
            push_digit(4'(i + 1));
            send_frame(codes[i], 0, 0);
        end
        repeat (SETTLE) @(negedge clk);
        while (exp_q.size() != 0) begin
            exp_ev = exp_q.pop_front();
            checks++;
            if (rd_idx >= obs_q.size()) begin
                failures++;
                $display("[TB] FAIL digits_evt: got none expected %h", exp_ev);
            end else begin
                obs_ev = obs_q[rd_idx];
                rd_idx++;
                if (obs_ev !== exp_ev) begin
                    failures++;
                    $display("[TB] FAIL digits_evt: got %h expected %h", obs_ev, exp_ev);
                end
            end
        end
        checks++;
        if (obs_q.size() != rd_idx) begin
            failures++;
            $display("[TB] FAIL digits_extra: got %0d events expected %0d", obs_q.size(), rd_idx);
            rd_idx = obs_q.size();
        end
        checks++;
        if (value !== 32'h3456_789A) begin
            failures++;
            $display("[TB] FAIL digits_value: got %h expected 3456789a", value);
        end
    endtask

    task automatic test_edit_keys();
        send_frame(8'h76, 0, 0);
        exp_val = '0;
        push_digit(4'h1); send_frame(8'h16, 0, 0);
        push_digit(4'h2); send_frame(8'h1E, 0, 0);
        push_digit(4'h3); send_frame(8'h26, 0, 0);
        push_digit(4'h4); send_frame(8'h25, 0, 0);
        send_frame(8'h66, 0, 0);
        checks++;
        if (value !== 32'h0000_0123) begin
            failures++;
            $display("[TB] FAIL backspace_value: got %h expected 00000123", value);
        end
        send_frame(8'h76, 0, 0);
        checks++;
        if (value !== '0) begin
            failures++;
            $display("[TB] FAIL esc_value: got %h expected 0", value);
        end
        exp_val = '0;
        exp_q.push_back({EV_VAL, 32'h0});
        send_frame(8'h5A, 0, 0);
        repeat (SETTLE) @(negedge clk);
        while (exp_q.size() != 0) begin
            exp_ev = exp_q.pop_front();
            checks++;
            if (rd_idx >= obs_q.size()) begin
                failures++;
                $display("[TB] FAIL edit_evt: got none expected %h", exp_ev);
            end else begin
                obs_ev = obs_q[rd_idx];
                rd_idx++;
                if (obs_ev !== exp_ev) begin
                    failures++;
                    $display("[TB] FAIL edit_evt: got %h expected %h", obs_ev, exp_ev);
                end
            end
        end
        checks++;
        if (obs_q.size() != rd_idx) begin
            failures++;
            $display("[TB] FAIL edit_extra: got %0d events expected %0d", obs_q.size(), rd_idx);
            rd_idx = obs_q.size();
        end
    endtask

    task automatic test_frame_errors();
        push_digit(4'h7);
        send_frame(8'h3D, 0, 0);
        exp_q.push_back({EV_ERR, exp_val});
        send_frame(8'h45, 1, 0);
        exp_q.push_back({EV_ERR, exp_val});
        send_frame(8'h45, 0, 1);
        push_digit(4'h0);
        send_frame(8'h45, 0, 0);
        repeat (SETTLE) @(negedge clk);
        while (exp_q.size() != 0) begin
            exp_ev = exp_q.pop_front();
            checks++;
            if (rd_idx >= obs_q.size()) begin
                failures++;
                $display("[TB] FAIL err_evt: got none expected %h", exp_ev);
            end else begin
                obs_ev = obs_q[rd_idx];
                rd_idx++;
                if (obs_ev !== exp_ev) begin
                    failures++;
                    $display("[TB] FAIL err_evt: got %h expected %h", obs_ev, exp_ev);
                end
            end
        end
        checks++;
        if (obs_q.size() != rd_idx) begin
            failures++;
            $display("[TB] FAIL err_extra: got %0d events expected %0d", obs_q.size(), rd_idx);
            rd_idx = obs_q.size();
        end
        checks++;
        if (value !== 32'h0000_0070) begin
            failures++;
            $display("[TB] FAIL err_value: got %h expected 00000070", value);
        end
    endtask

    task automatic test_timeout();
        exp_q.push_back({EV_ERR, exp_val});
        send_partial(8'h45, 4);
        repeat (TMO + 50) @(negedge clk);
        push_digit(4'hA);
        send_frame(8'h1C, 0, 0);
        repeat (SETTLE) @(negedge clk);
        while (exp_q.size() != 0) begin
            exp_ev = exp_q.pop_front();
            checks++;
            if (rd_idx >= obs_q.size()) begin
                failures++;
                $display("[TB] FAIL timeout_evt: got none expected %h", exp_ev);
            end else begin
                obs_ev = obs_q[rd_idx];
                rd_idx++;
                if (obs_ev !== exp_ev) begin
                    failures++;
                    $display("[TB] FAIL timeout_evt: got %h expected %h", obs_ev, exp_ev);
                end
            end
        end
        checks++;
        if (obs_q.size() != rd_idx) begin
            failures++;
            $display("[TB] FAIL timeout_extra: got %0d events expected %0d", obs_q.size(), rd_idx);
            rd_idx = obs_q.size();
        end
        checks++;
        if (value[3:0] !== 4'hA) begin
            failures++;
            $display("[TB] FAIL timeout_nibble: got %h expected a", value[3:0]);
        end
    endtask

    task automatic test_ext_and_reset();
        exp_q.push_back({EV_VAL, exp_val});
        send_frame(8'hE0, 0, 0);
        send_frame(8'h5A, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h16, 0, 0);
        checks++;
        if (value !== exp_val) begin
            failures++;
            $display("[TB] FAIL ext_value: got %h expected %h", value, exp_val);
        end
        send_partial(8'h2E, 4);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({value, key_stb, value_valid, frame_err} !== '0) begin
            failures++;
            $display("[TB] FAIL midframe_reset: got value=%h pulses=%b expected all 0",
                     value, {key_stb, value_valid, frame_err});
        end
        rst_n = 1'b1;
        exp_val = '0;
        repeat (TMO + 20) @(negedge clk);
        push_digit(4'h8);
        send_frame(8'h3E, 0, 0);
        repeat (SETTLE) @(negedge clk);
        while (exp_q.size() != 0) begin
            exp_ev = exp_q.pop_front();
            checks++;
            if (rd_idx >= obs_q.size()) begin
                failures++;
                $display("[TB] FAIL ext_evt: got none expected %h", exp_ev);
            end else begin
                obs_ev = obs_q[rd_idx];
                rd_idx++;
                if (obs_ev !== exp_ev) begin
                    failures++;
                    $display("[TB] FAIL ext_evt: got %h expected %h", obs_ev, exp_ev);
                end
            end
        end
        checks++;
        if (obs_q.size() != rd_idx) begin
            failures++;
            $display("[TB] FAIL ext_extra: got %0d events expected %0d", obs_q.size(), rd_idx);
            rd_idx = obs_q.size();
        end
        checks++;
        if (value !== 32'h0000_0008) begin
            failures++;
            $display("[TB] FAIL post_reset_value: got %h expected 00000008", value);
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_ten_digits();
        test_edit_keys();
        test_frame_errors();
        test_timeout();
        test_ext_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
